// File: rtl/inst_ram_if.sv
// Instruction RAM bus: read port, load/write port and status.
// The master drives requests; the slave returns the registered read result.
interface inst_ram_if #(
    parameter int INST_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);
    logic                  ce;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  stall;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [INST_WIDTH-1:0] wdata;
    logic [INST_WIDTH-1:0] inst;
    logic                  inst_valid;
    logic                  addr_err;
    logic                  ready;

    modport master (
        output ce, addr, stall, we, waddr, wdata,
        input  inst, inst_valid, addr_err, ready
    );

    modport slave (
        input  ce, addr, stall, we, waddr, wdata,
        output inst, inst_valid, addr_err, ready
    );
endinterface

// File: rtl/inst_ram.sv
// Instruction RAM with 1-cycle registered read, load port,
// and an optional zero-fill sweep after reset.
module inst_ram #(
    parameter int INST_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int DEPTH_LOG2     = 8,
    parameter int ALIGN_BITS     = 3,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic clk,
    input logic rst,
    inst_ram_if.slave bus
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int IDX_LO = ALIGN_BITS;
    localparam int IDX_HI = ALIGN_BITS + DEPTH_LOG2 - 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t state, state_nxt;

    logic [DEPTH_LOG2-1:0] cnt, cnt_nxt;
    logic [INST_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] ridx, widx, wr_idx;
    logic                  rlegal, wlegal, port_we, wr_en;
    logic [INST_WIDTH-1:0] wr_data, rdata;

    logic [INST_WIDTH-1:0] inst_q, inst_nxt;
    logic                  valid_q, valid_nxt;
    logic                  err_q, err_nxt;

    assign ridx = bus.addr[IDX_HI:IDX_LO];
    assign widx = bus.waddr[IDX_HI:IDX_LO];

    assign rlegal = (bus.addr[ADDR_WIDTH-1:IDX_HI+1] == '0)
                 && (bus.addr[ALIGN_BITS-1:0] == '0);
    assign wlegal = (bus.waddr[ADDR_WIDTH-1:IDX_HI+1] == '0)
                 && (bus.waddr[ALIGN_BITS-1:0] == '0);

    assign port_we = !rst && (state == RUN) && bus.we && wlegal;

    // Write-first: a same-edge write to the read index forwards wdata
    assign rdata = (port_we && (widx == ridx)) ? bus.wdata : mem[ridx];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        inst_nxt  = inst_q;
        valid_nxt = valid_q;
        err_nxt   = err_q;
        wr_en     = 1'b0;
        wr_idx    = widx;
        wr_data   = bus.wdata;
        if (rst) begin
            state_nxt = (CLEAR_ON_RESET != 0) ? INIT : RUN;
            cnt_nxt   = '0;
            inst_nxt  = '0;
            valid_nxt = 1'b0;
            err_nxt   = 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    wr_en     = 1'b1;
                    wr_idx    = cnt;
                    wr_data   = '0;
                    cnt_nxt   = cnt + DEPTH_LOG2'(1);
                    inst_nxt  = '0;
                    valid_nxt = 1'b0;
                    err_nxt   = 1'b0;
                    if (cnt == '1) state_nxt = RUN;
                end
                RUN: begin
                    wr_en = port_we;
                    if (!bus.stall) begin
                        inst_nxt  = (bus.ce && rlegal) ? rdata : '0;
                        valid_nxt = bus.ce;
                        err_nxt   = bus.ce && !rlegal;
                    end
                end
                default: state_nxt = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        inst_q  <= inst_nxt;
        valid_q <= valid_nxt;
        err_q   <= err_nxt;
    end

    // Storage has no reset; only the sweep clears it
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign bus.inst       = inst_q;
    assign bus.inst_valid = valid_q;
    assign bus.addr_err   = err_q;
    assign bus.ready      = (state == RUN);
endmodule
